// File: rtl/serial_cmp_ctrl.sv
// Serial magnitude comparator controller: walks two captured operands MSB-pair first
// through an external 2-bit comparator slice and registers the final lt/gt/eq/err result.
module serial_cmp_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       cmp_a,
    output logic [1:0]       cmp_b,
    input  logic             cmp_lt,
    input  logic             cmp_gt,
    input  logic             cmp_eq,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq,
    output logic             err
);

    localparam int unsigned NPAIR = WIDTH / 2;
    localparam int unsigned IW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]   r_idx;
    logic            r_lt;
    logic            r_gt;
    logic            r_eq;
    logic            r_err;

    logic            w_onehot;
    logic            w_last;
    logic            w_accept;
    logic [1:0]      w_pair_a;
    logic [1:0]      w_pair_b;

    assign w_onehot = ({cmp_lt, cmp_gt, cmp_eq} == 3'b100) ||
                      ({cmp_lt, cmp_gt, cmp_eq} == 3'b010) ||
                      ({cmp_lt, cmp_gt, cmp_eq} == 3'b001);
    assign w_last   = (r_idx == '0);
    assign w_accept = start && (r_state != S_RUN);

    initial begin : param_check
        assert (WIDTH >= 2 && (WIDTH % 2) == 0)
            else $fatal(1, "serial_cmp_ctrl: WIDTH must be even and >= 2");
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = start ? S_RUN : S_IDLE;
            S_RUN: begin
                if (!w_onehot || cmp_gt || cmp_lt || (cmp_eq && w_last)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_DONE:  w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Pair selection from the shadow operands for the current index
    always_comb begin
        w_pair_a = '0;
        w_pair_b = '0;
        for (int unsigned k = 0; k < NPAIR; k++) begin
            if (r_idx == IW'(k)) begin
                w_pair_a = r_a[2*k +: 2];
                w_pair_b = r_b[2*k +: 2];
            end
        end
    end

    // Output logic
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        cmp_a = '0;
        cmp_b = '0;
        case (r_state)
            S_RUN: begin
                busy  = 1'b1;
                cmp_a = w_pair_a;
                cmp_b = w_pair_b;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: shadow operands, pair index and result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= IW'(NPAIR - 1);
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_idx <= IW'(NPAIR - 1);
            r_lt  <= 1'b0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_err <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (!w_onehot) begin
                r_err <= 1'b1;
                r_lt  <= 1'b0;
                r_gt  <= 1'b0;
                r_eq  <= 1'b0;
            end else if (cmp_gt) begin
                r_gt <= 1'b1;
            end else if (cmp_lt) begin
                r_lt <= 1'b1;
            end else if (w_last) begin
                r_eq <= 1'b1;
            end else begin
                r_idx <= r_idx - IW'(1);
            end
        end
    end

    assign lt  = r_lt;
    assign gt  = r_gt;
    assign eq  = r_eq;
    assign err = r_err;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Self-checking bench for serial_cmp_ctrl: behavioural comparator slice plus a
// pair-walk reference model; directed scenarios followed by randomized operands.
module tb_serial_cmp_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NPAIR = WIDTH / 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       cmp_a;
    logic [1:0]       cmp_b;
    logic             cmp_lt;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             busy;
    logic             done;
    logic             lt;
    logic             gt;
    logic             eq;
    logic             err;

    logic             f_force;
    int               n_checks;
    int               n_errors;
    logic [3:0]       held_flags;

    serial_cmp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .cmp_a  (cmp_a),
        .cmp_b  (cmp_b),
        .cmp_lt (cmp_lt),
        .cmp_gt (cmp_gt),
        .cmp_eq (cmp_eq),
        .busy   (busy),
        .done   (done),
        .lt     (lt),
        .gt     (gt),
        .eq     (eq),
        .err    (err)
    );

    always #5 clk = ~clk;

    // Ideal 2-bit slice; f_force makes it report lt and gt together
    assign cmp_lt = f_force ? 1'b1 : (cmp_a < cmp_b);
    assign cmp_gt = f_force ? 1'b1 : (cmp_a > cmp_b);
    assign cmp_eq = f_force ? 1'b0 : (cmp_a == cmp_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned pair_of(input logic [WIDTH-1:0] v, input int unsigned p);
        return (int'(v) >> (2 * p)) & 3;
    endfunction

    // One comparison, entered at a negedge with the DUT in IDLE or DONE; leaves at the DONE negedge.
    task automatic run_cmp(input logic [WIDTH-1:0] opa, input logic [WIDTH-1:0] opb,
                           input int fault_at, input string tag);
        int unsigned nat_len;
        int unsigned exp_len;
        logic [3:0]  exp_flags;
        int unsigned p;

        nat_len = NPAIR;
        for (int unsigned k = 0; k < NPAIR; k++) begin
            p = NPAIR - 1 - k;
            if (pair_of(opa, p) != pair_of(opb, p)) begin
                nat_len = k + 1;
                break;
            end
        end
        if (opa < opb)       exp_flags = 4'b1000;
        else if (opa > opb)  exp_flags = 4'b0100;
        else                 exp_flags = 4'b0010;
        exp_len = nat_len;
        if (fault_at >= 0 && fault_at < int'(nat_len)) begin
            exp_len   = fault_at + 1;
            exp_flags = 4'b0001;
        end

        a     = opa;
        b     = opb;
        start = 1'b1;
        @(posedge clk);
        for (int unsigned k = 0; k < exp_len; k++) begin
            @(negedge clk);
            f_force = (int'(k) == fault_at);
            check({tag, ".busy"},  busy, 1);
            check({tag, ".done"},  done, 0);
            check({tag, ".cmp_a"}, cmp_a, pair_of(opa, NPAIR - 1 - k));
            check({tag, ".cmp_b"}, cmp_b, pair_of(opb, NPAIR - 1 - k));
            check({tag, ".flags_run"}, {lt, gt, eq, err}, 0);
            // Disturb inputs during RUN; the captured operands must not move
            start = 1'($urandom);
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
        end
        @(negedge clk);
        f_force = 1'b0;
        check({tag, ".busy_done"}, busy, 0);
        check({tag, ".done"}, done, 1);
        check({tag, ".flags"}, {lt, gt, eq, err}, exp_flags);
        held_flags = exp_flags;
    endtask

    task automatic idle_gap(input string tag);
        start = 1'b0;
        @(negedge clk);
        check({tag, ".idle_done"}, done, 0);
        check({tag, ".idle_busy"}, busy, 0);
        check({tag, ".idle_cmp"}, {cmp_a, cmp_b}, 0);
        check({tag, ".hold"}, {lt, gt, eq, err}, held_flags);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] mask;
        int               fa;

        n_checks   = 0;
        n_errors   = 0;
        f_force    = 1'b0;
        held_flags = '0;
        rst        = 1'b1;
        start      = 1'b1;
        a          = 8'hFF;
        b          = 8'h00;
        repeat (3) @(negedge clk);
        check("reset.busy", busy, 0);
        check("reset.done", done, 0);
        check("reset.flags", {lt, gt, eq, err}, 0);
        check("reset.cmp", {cmp_a, cmp_b}, 0);
        rst   = 1'b0;
        start = 1'b0;
        idle_gap("reset_idle");

        run_cmp(8'hB4, 8'hB4, -1, "eq_b4");
        idle_gap("eq_b4");
        run_cmp(8'h80, 8'h7F, -1, "gt_msb");
        idle_gap("gt_msb");
        run_cmp(8'h12, 8'h13, -1, "lt_lsb");
        run_cmp(8'hFF, 8'h00, -1, "b2b_gt");
        idle_gap("b2b_gt");
        run_cmp(8'h00, 8'hFF, -1, "ignore_start");
        idle_gap("ignore_start");

        // Reset in the second RUN cycle aborts without a done pulse
        a     = 8'h55;
        b     = 8'h55;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("abort.busy1", busy, 1);
        @(negedge clk);
        check("abort.busy2", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.flags", {lt, gt, eq, err}, 0);
        check("abort.cmp", {cmp_a, cmp_b}, 0);
        held_flags = '0;
        idle_gap("abort_after");

        run_cmp(8'h3C, 8'h3C, 0, "fault_first");
        idle_gap("fault_first");
        run_cmp(8'hA5, 8'hA5, 2, "fault_third");

        for (int i = 0; i < 60; i++) begin
            ra   = WIDTH'($urandom);
            mask = WIDTH'(8'hFF >> $urandom_range(0, 8));
            rb   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : (ra ^ (mask & WIDTH'($urandom)));
            fa   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NPAIR - 1)) : -1;
            run_cmp(ra, rb, fa, "rand");
            if ($urandom_range(0, 1) == 1) idle_gap("rand");
        end
        idle_gap("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_cmp_ctrl.md
SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: start  input  1  request to compare a and b; sampled only in IDLE or DONE.
REQ-005 Port: a  input  WIDTH  operand A, unsigned; captured on accepted start.
REQ-006 Port: b  input  WIDTH  operand B, unsigned; captured on accepted start.
REQ-007 Port: cmp_a  output  2  operand-A bit pair driven to the external 2-bit comparator slice.
REQ-008 Port: cmp_b  output  2  operand-B bit pair driven to the slice.
REQ-009 Port: cmp_lt, cmp_gt, cmp_eq  input  1 each  combinational slice results for cmp_a vs cmp_b.
REQ-010 Port: busy  output  1  high while a comparison is in progress (RUN).
REQ-011 Port: done  output  1  one-cycle pulse when a result is valid.
REQ-012 Port: lt, gt, eq  output  1 each  registered final result, A<B, A>B, A==B.
REQ-013 Port: err  output  1  registered flag, slice returned a non-one-hot result.

Function
REQ-014 FSM SHALL have states IDLE, RUN, DONE; encoding free.
REQ-015 IDLE or DONE with start=1: capture a, b into shadow registers, load pair index to WIDTH/2-1, clear lt/gt/eq/err, go to RUN.
REQ-016 IDLE with start=0: stay; DONE with start=0: go to IDLE.
REQ-017 RUN: cmp_a/cmp_b SHALL be shadow bits [2i+1:2i] for current index i (MSB pair first); in IDLE/DONE they SHALL be 2'b00.
REQ-018 RUN, cmp_gt=1 only: set gt=1, go to DONE.
REQ-019 RUN, cmp_lt=1 only: set lt=1, go to DONE.
REQ-020 RUN, cmp_eq=1 only and i>0: decrement i, stay in RUN.
REQ-021 RUN, cmp_eq=1 only and i=0: set eq=1, go to DONE.
REQ-022 RUN, slice inputs not exactly one-hot (none or >1 high): set err=1, lt=gt=eq=0, go to DONE.
REQ-023 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-024 Latency: accepted start at edge E -> RUN from E; done high in the cycle after the deciding RUN cycle; RUN length = 1 + number of equal leading pairs, max WIDTH/2 cycles.
REQ-025 lt/gt/eq/err SHALL hold their value from DONE until the next accepted start or reset; at most one of lt/gt/eq/err high.
REQ-026 start during RUN SHALL be ignored; shadow operands SHALL not change during RUN regardless of a/b.
REQ-027 start in DONE SHALL be accepted in that cycle, allowing back-to-back comparisons with no idle cycle.

Reset
REQ-028 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, lt=gt=eq=err=0, index=WIDTH/2-1, shadow operands=0; rst dominates start.
REQ-029 rst during RUN SHALL abort the comparison with no done pulse.

Verification
REQ-030 WIDTH=8, a=0xB4, b=0xB4, start 1 cycle -> busy 4 cycles, cmp_a sequence 2,3,1,0; then done=1, eq=1, lt=gt=err=0.
REQ-031 a=0x80, b=0x7F -> 1 RUN cycle (cmp_a=2, cmp_b=1, slice gt), next cycle done=1, gt=1.
REQ-032 a=0x12, b=0x13 -> 4 RUN cycles, last pair 2 vs 3, done=1, lt=1; then start held high in DONE with a=0xFF, b=0x00 -> RUN immediately, gt=1 after 1 RUN cycle.
REQ-033 Start a=0x00, b=0xFF; pulse start again and change a/b in RUN cycle 1 -> ignored, result lt=1 for original operands.
REQ-034 Start a=0x55, b=0x55, assert rst in RUN cycle 2 -> next cycle IDLE, all outputs 0, no done pulse.
REQ-035 Force cmp_lt=cmp_gt=1 in first RUN cycle -> done=1, err=1, lt=gt=eq=0.
